// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: hunts for a start-of-frame beat, collects N channel
// samples into a shadow frame and publishes each complete frame in one cycle.

module tdm_demux_slot #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (we) q_d = wdata;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

module tdm_demux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [W-1:0]         In_Data,
  input  logic                 In_Valid,
  input  logic                 In_Sof,
  output logic [N*W-1:0]       Out_Data,
  output logic                 Out_Valid,
  output logic                 Sync,
  output logic [$clog2(N)-1:0] Ch_Idx,
  output logic                 Err
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  state_t         state_d, state_q;
  logic [IW-1:0]  ch_idx_d, ch_idx_q;
  logic [N*W-1:0] out_data_d, out_data_q;
  logic           out_valid_d, out_valid_q;
  logic           err_d, err_q;

  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [N-2:0]   slot_we;
  logic [N-2:0][W-1:0] shadow;

  // Only slots 0..N-2 are buffered; the closing beat goes straight into Out_Data.
  for (genvar k = 0; k < N - 1; k++) begin : g_slot
    tdm_demux_slot #(.W(W)) u_slot (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (slot_we[k]),
      .wdata (In_Data),
      .q     (shadow[k])
    );
  end

  always_comb begin
    slot_we = '0;
    for (int k = 0; k < N - 1; k++)
      slot_we[k] = wr_en && (wr_idx == IW'(k));
  end

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    if (In_Valid) begin
      unique case (state_q)
        HUNT: begin
          if (In_Sof) begin
            wr_en    = 1'b1;
            ch_idx_d = IW'(1);
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (In_Sof) begin
            // A Sof mid-frame abandons the partial frame and restarts on this beat.
            err_d    = (ch_idx_q != '0);
            wr_en    = 1'b1;
            ch_idx_d = IW'(1);
          end else if (ch_idx_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (ch_idx_q == LAST) begin
            out_data_d  = {In_Data, shadow};
            out_valid_d = 1'b1;
            ch_idx_d    = '0;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = ch_idx_q;
            ch_idx_d = ch_idx_q + IW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= HUNT;
      ch_idx_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
  assign Sync      = (state_q == COLLECT);
  assign Ch_Idx    = ch_idx_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios plus random beats, checked
// against a queue-based frame model.

module tb_tdm_demux;

  localparam int N = 4;
  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [W-1:0]   In_Data;
  logic           In_Valid;
  logic           In_Sof;
  logic [N*W-1:0] Out_Data;
  logic           Out_Valid;
  logic           Sync;
  logic [1:0]     Ch_Idx;
  logic           Err;

  int n_total = 0;
  int n_pass  = 0;

  bit             locked;
  logic [W-1:0]   frame[$];
  logic [N*W-1:0] exp_out;
  logic           exp_valid;
  logic           exp_err;

  tdm_demux #(.N(N), .W(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Sof    (In_Sof),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Sync      (Sync),
    .Ch_Idx    (Ch_Idx),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    locked    = 1'b0;
    frame.delete();
    exp_out   = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Frame-level view: a locked receiver holds the samples seen so far.
  task automatic model_beat(input logic v, input logic s, input logic [W-1:0] d);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!v) return;
    if (!locked) begin
      if (s) begin
        frame.delete();
        frame.push_back(d);
        locked = 1'b1;
      end
    end else if (s) begin
      exp_err = (frame.size() != 0);
      frame.delete();
      frame.push_back(d);
    end else if (frame.size() == 0) begin
      exp_err = 1'b1;
      locked  = 1'b0;
    end else begin
      frame.push_back(d);
      if (frame.size() == N) begin
        for (int k = 0; k < N; k++) exp_out[k*W +: W] = frame[k];
        exp_valid = 1'b1;
        frame.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  64'(Out_Data),  64'(exp_out));
    chk({tag, ".valid"}, 64'(Out_Valid), 64'(exp_valid));
    chk({tag, ".err"},   64'(Err),       64'(exp_err));
    chk({tag, ".sync"},  64'(Sync),      64'(locked));
    chk({tag, ".idx"},   64'(Ch_Idx),    64'(frame.size()));
    chk({tag, ".excl"},  64'(Out_Valid & Err), 64'(0));
  endtask

  task automatic cyc(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    In_Valid = v;
    In_Sof   = s;
    In_Data  = d;
    @(posedge Clk);
    #1;
    model_beat(v, s, d);
    check_all(tag);
  endtask

  task automatic frame4(input string tag, input logic [N*W-1:0] f);
    for (int k = 0; k < N; k++) cyc(tag, 1'b1, (k == 0), f[k*W +: W]);
  endtask

  // Raised between edges so the clear must be asynchronous to show up.
  task automatic do_reset(input string tag);
    Rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    In_Valid = 1'b0;
    In_Sof   = 1'b0;
    In_Data  = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_all("reset");
    Rst = 1'b0;
    cyc("post_rst", 1'b0, 1'b0, 8'h00);

    // Single frame; result appears one cycle after the last beat.
    frame4("f1", 32'h44332211);
    chk("f1.const", 64'(Out_Data), 64'h44332211);
    cyc("f1.hold", 1'b0, 1'b0, 8'h00);

    // Back-to-back frames, no idle cycles.
    frame4("b2b_a", 32'h44332211);
    chk("b2b_a.const", 64'(Out_Data), 64'h44332211);
    frame4("b2b_b", 32'hA4A3A2A1);
    chk("b2b_b.const", 64'(Out_Data), 64'hA4A3A2A1);

    // Non-Sof beats while hunting are dropped.
    do_reset("rst2");
    cyc("hunt0", 1'b1, 1'b0, 8'h55);
    cyc("hunt1", 1'b1, 1'b0, 8'h66);
    frame4("hunt_f", 32'h04030201);
    chk("hunt.const", 64'(Out_Data), 64'h04030201);

    // Sof arriving mid-frame.
    cyc("mid0", 1'b1, 1'b1, 8'h11);
    cyc("mid1", 1'b1, 1'b0, 8'h22);
    cyc("mid_sof", 1'b1, 1'b1, 8'h77);
    chk("mid_sof.errc", 64'(Err), 64'd1);
    chk("mid_sof.keep", 64'(Out_Data), 64'h04030201);
    cyc("mid2", 1'b1, 1'b0, 8'h88);
    cyc("mid3", 1'b1, 1'b0, 8'h99);
    cyc("mid4", 1'b1, 1'b0, 8'hAA);
    chk("mid.const", 64'(Out_Data), 64'hAA998877);

    // Missing Sof after a complete frame drops lock.
    cyc("nosof", 1'b1, 1'b0, 8'hBB);
    chk("nosof.sync", 64'(Sync), 64'd0);
    chk("nosof.keep", 64'(Out_Data), 64'hAA998877);

    // Gappy partial frame, then reset mid-frame.
    frame4("pre34", 32'h31323334);
    cyc("tog0", 1'b1, 1'b1, 8'hC0);
    cyc("tog1", 1'b0, 1'b0, 8'hEE);
    cyc("tog2", 1'b1, 1'b0, 8'hC1);
    cyc("tog3", 1'b0, 1'b1, 8'hEE);
    cyc("tog4", 1'b1, 1'b0, 8'hC2);
    do_reset("rst_mid");
    chk("rst_mid.zero", 64'(Out_Data), 64'd0);
    cyc("rel0", 1'b0, 1'b0, 8'h00);
    cyc("rel1", 1'b1, 1'b0, 8'hC3);
    cyc("rel2", 1'b1, 1'b0, 8'hC4);
    frame4("rel_f", 32'hD4D3D2D1);
    chk("rel.const", 64'(Out_Data), 64'hD4D3D2D1);

    // Random beats, Sof biased toward frame boundaries.
    for (int i = 0; i < 3000; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      if (frame.size() == 0) s = ($urandom_range(0, 7) != 0);
      else                   s = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      cyc("rnd", v, s, W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter N, default 4, number of time-division channels per frame (N >= 2).
REQ-002 Parameter W, default 8, width in bits of one channel sample.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous and active-high.
REQ-005 In_Data  input  W  serial TDM sample stream, one channel sample per accepted beat.
REQ-006 In_Valid  input  1  beat qualifier; In_Data and In_Sof are ignored when low.
REQ-007 In_Sof  input  1  start-of-frame marker; high only on the channel-0 beat.
REQ-008 Out_Data  output  N*W  last complete frame; channel k occupies bits [k*W+W-1 : k*W].
REQ-009 Out_Valid  output  1  one-cycle pulse when Out_Data has just been updated with a new frame.
REQ-010 Sync  output  1  high while the block is frame-locked (state COLLECT).
REQ-011 Ch_Idx  output  clog2(N)  index of the channel slot the next accepted beat will fill.
REQ-012 Err  output  1  one-cycle pulse on a framing error.

Function
REQ-013 The block shall implement two states: HUNT (unlocked) and COLLECT (locked).
REQ-014 In HUNT, beats with In_Sof low shall be discarded; Ch_Idx shall hold 0.
REQ-015 In HUNT, a beat with In_Valid=1 and In_Sof=1 shall be stored as channel 0, set Ch_Idx to 1, and move to COLLECT.
REQ-016 In COLLECT, each beat with In_Valid=1 and In_Sof=0 shall be stored in the shadow slot Ch_Idx, then Ch_Idx shall increment.
REQ-017 When the beat filling slot N-1 is accepted, the full shadow frame (including that beat) shall be copied to Out_Data and Out_Valid pulsed high on the next cycle (latency 1 cycle from the last beat); Ch_Idx shall wrap to 0.
REQ-018 In COLLECT with Ch_Idx=0, a beat with In_Sof=1 shall be stored as channel 0 and Ch_Idx set to 1 with no error.
REQ-019 In COLLECT with Ch_Idx=0, a beat with In_Sof=0 shall pulse Err, discard the beat, and return to HUNT.
REQ-020 In COLLECT with Ch_Idx != 0, a beat with In_Sof=1 shall pulse Err, drop the partial frame, store the beat as channel 0, set Ch_Idx to 1, and stay in COLLECT.
REQ-021 Cycles with In_Valid=0 shall change no state, counters or outputs other than deasserting Out_Valid and Err.
REQ-022 Out_Data shall hold its value between updates; a partial or dropped frame shall never reach Out_Data.
REQ-023 Out_Valid and Err shall each be high for exactly one cycle per event and shall never be high together.
REQ-024 Back-to-back frames at one beat per cycle shall be supported with no idle cycles and no lost beats.
REQ-025 Sync shall equal 1 in COLLECT and 0 in HUNT, registered, with no combinational path from inputs.

Reset
REQ-026 Rst high shall immediately force state HUNT, Ch_Idx=0, Out_Data=0, Out_Valid=0, Sync=0, Err=0, and clear the shadow frame.
REQ-027 Rst asserted mid-frame shall discard the partial frame; after release the block shall resynchronise only on the next In_Sof beat.
REQ-028 Out_Valid and Err shall not pulse in the first cycle after reset release.

Verification
REQ-029 N=4,W=8: reset, then beats (Sof=1,0x11),(0x22),(0x33),(0x44) in consecutive cycles -> one cycle after 0x44: Out_Data=0x44332211, Out_Valid=1 for one cycle, Sync=1.
REQ-030 Two back-to-back frames 0x11..0x44 then 0xA1..0xA4 with no gaps -> Out_Valid pulses 4 cycles apart; Out_Data=0x44332211 then 0xA4A3A2A1.
REQ-031 From HUNT, beats 0x55,0x66 with Sof=0 then a valid frame -> first two beats ignored, Sync stays 0 until the Sof beat, Out_Data=frame only.
REQ-032 Frame 0x11,0x22 then Sof beat 0x77 followed by 0x88,0x99,0xAA -> Err pulse on the 0x77 beat, Out_Data=0xAA998877, prior Out_Data unchanged until then.
REQ-033 After a complete frame, next beat 0xBB with Sof=0 -> Err pulse, Sync=0, Out_Data unchanged.
REQ-034 In_Valid toggled 1/0 every cycle during a frame, then Rst asserted after channel 2 -> all outputs 0 asynchronously, no Out_Valid after release until a full new Sof-led frame.
